// File: rtl/bcd_countdown.sv
// bcd_countdown: 4-digit BCD mm:ss countdown core.
// The game FSM drives load/run. This block returns the current count to the
// display mux, and returns zero/done to the FSM.
// A count tick happens once per TICK_DIV clocks, or once per TICK_DIV_SIM
// clocks while turbosim is high.
// Optional feature macro: BCD_COUNTDOWN_BLINK_EN. When it is defined, blink
// follows the prescaler half-period and is held high at zero.

module bcd_countdown #(
  parameter int unsigned TICK_DIV     = 100_000_000,
  parameter int unsigned TICK_DIV_SIM = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        turbosim,
  input  logic        load,
  input  logic [15:0] load_value,
  input  logic        run,
  output logic [15:0] bcd,
  output logic        zero,
  output logic        done,
  output logic        tick,
  output logic        blink
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] DIV_M1     = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] DIV_SIM_M1 = PW'(TICK_DIV_SIM - 1);

  logic [15:0]   bcd_q, bcd_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          tick_q, tick_d;
  logic          done_q, done_d;
  logic [PW-1:0] div_m1;
  logic          tc;

  // Clamp each digit into its legal BCD range.
  // The tens-of-seconds digit is limited to 5.
  function automatic logic [15:0] bcd_sanitise(input logic [15:0] v);
    logic [3:0] m10, m1, s10, s1;
    m10 = (v[15:12] > 4'd9) ? 4'd9 : v[15:12];
    m1  = (v[11:8]  > 4'd9) ? 4'd9 : v[11:8];
    s10 = (v[7:4]   > 4'd5) ? 4'd5 : v[7:4];
    s1  = (v[3:0]   > 4'd9) ? 4'd9 : v[3:0];
    return {m10, m1, s10, s1};
  endfunction

  // Decrement mm:ss by one second, borrowing digit by digit.
  // This is only ever called on a non-zero count.
  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [3:0] m10, m1, s10, s1;
    {m10, m1, s10, s1} = v;
    if (s1 != 4'd0) begin
      s1 = s1 - 4'd1;
    end else begin
      s1 = 4'd9;
      if (s10 != 4'd0) begin
        s10 = s10 - 4'd1;
      end else begin
        s10 = 4'd5;
        if (m1 != 4'd0) begin
          m1 = m1 - 4'd1;
        end else begin
          m1  = 4'd9;
          m10 = m10 - 4'd1;
        end
      end
    end
    return {m10, m1, s10, s1};
  endfunction

  assign zero   = (bcd_q == 16'h0000);
  assign div_m1 = turbosim ? DIV_SIM_M1 : DIV_M1;
  // Compare with >= so that switching to a shorter divisor mid-count
  // fires at once instead of running past the terminal count.
  assign tc     = run && !zero && !load && (presc_q >= div_m1);

  // Next-state logic. A load overrides both run and the terminal count.
  always_comb begin
    bcd_d   = bcd_q;
    presc_d = presc_q;
    tick_d  = 1'b0;
    done_d  = 1'b0;
    if (load) begin
      bcd_d   = bcd_sanitise(load_value);
      presc_d = '0;
    end else if (!run || zero) begin
      presc_d = '0;
    end else if (tc) begin
      bcd_d   = bcd_dec(bcd_q);
      presc_d = '0;
      tick_d  = 1'b1;
      done_d  = (bcd_d == 16'h0000);
    end else begin
      presc_d = presc_q + PW'(1);
    end
  end

  // State and registered strobes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bcd_q   <= 16'h0000;
      presc_q <= '0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      bcd_q   <= bcd_d;
      presc_q <= presc_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
    end
  end

  assign bcd  = bcd_q;
  assign tick = tick_q;
  assign done = done_q;

`ifdef BCD_COUNTDOWN_BLINK_EN
  localparam logic [PW-1:0] HALF     = PW'(TICK_DIV / 2);
  localparam logic [PW-1:0] HALF_SIM = PW'(TICK_DIV_SIM / 2);

  logic          blink_q, blink_d;
  logic [PW-1:0] half;

  assign half = turbosim ? HALF_SIM : HALF;

  // Blink stays solid at zero (alarm flash) and is high for the upper half
  // of each prescaler period.
  always_comb begin
    blink_d = (bcd_d == 16'h0000) || (presc_d >= half);
  end

  // Registered blink output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_q <= 1'b0;
    end else begin
      blink_q <= blink_d;
    end
  end

  assign blink = blink_q;
`else
  assign blink = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_countdown.sv
// Testbench for bcd_countdown (turbosim=1, TICK_DIV_SIM=10).

module tb_bcd_countdown;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        turbosim;
  logic        load;
  logic [15:0] load_value;
  logic        run;
  logic [15:0] bcd;
  logic        zero, done, tick, blink;

  bcd_countdown #(.TICK_DIV(100_000_000), .TICK_DIV_SIM(10)) dut (
    .clk(clk), .reset_n(reset_n), .turbosim(turbosim), .load(load),
    .load_value(load_value), .run(run), .bcd(bcd), .zero(zero),
    .done(done), .tick(tick), .blink(blink)
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] lv; logic [15:0] exp_bcd; logic exp_zero; } load_vec_t;
  typedef struct { logic [15:0] lv; logic [15:0] exp_bcd; logic exp_done; } dec_vec_t;
  typedef struct { logic [15:0] bcd; logic zero; logic done; } sb_t;

  sb_t sb_q[$];
  int  n_cmp  = 0;
  int  n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [15:0] b, input logic z, input logic d);
    sb_t e;
    e.bcd = b; e.zero = z; e.done = d;
    sb_q.push_back(e);
  endtask

  task automatic pop_check(input string name);
    sb_t e;
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: scoreboard empty, got bcd %h", name, bcd);
    end else begin
      e = sb_q.pop_front();
      chk({name, ".bcd"}, {16'h0, bcd}, {16'h0, e.bcd});
      chk({name, ".zero"}, {31'h0, zero}, {31'h0, e.zero});
      chk({name, ".done"}, {31'h0, done}, {31'h0, e.done});
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic r);
    load = 1'b1; load_value = v; run = r;
    step();
    load = 1'b0;
  endtask

  task automatic wait_tick(input int limit, output int cycles, output bit seen);
    cycles = 0;
    seen   = 1'b0;
    while (!seen && cycles < limit) begin
      step();
      cycles++;
      if (tick) seen = 1'b1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    load_vec_t lvec[8];
    dec_vec_t  dvec[7];
    int  cyc, cnt, cnt2;
    bit  seen;
    int  exp_blink_hi;

    lvec[0] = '{16'h9F7A, 16'h9959, 1'b0};
    lvec[1] = '{16'h0000, 16'h0000, 1'b1};
    lvec[2] = '{16'h1234, 16'h1234, 1'b0};
    lvec[3] = '{16'hFFFF, 16'h9959, 1'b0};
    lvec[4] = '{16'h5A6B, 16'h5959, 1'b0};
    lvec[5] = '{16'h0060, 16'h0050, 1'b0};
    lvec[6] = '{16'h8000, 16'h8000, 1'b0};
    lvec[7] = '{16'h0105, 16'h0105, 1'b0};

    dvec[0] = '{16'h0105, 16'h0104, 1'b0};
    dvec[1] = '{16'h0100, 16'h0059, 1'b0};
    dvec[2] = '{16'h1000, 16'h0959, 1'b0};
    dvec[3] = '{16'h0010, 16'h0009, 1'b0};
    dvec[4] = '{16'h2000, 16'h1959, 1'b0};
    dvec[5] = '{16'h1100, 16'h1059, 1'b0};
    dvec[6] = '{16'h0001, 16'h0000, 1'b1};

    reset_n = 1'b0; turbosim = 1'b1; load = 1'b0; load_value = 16'h0; run = 1'b0;
    #23 reset_n = 1'b1;
    #1;
    chk("rst.bcd",   {16'h0, bcd},  32'h0);
    chk("rst.zero",  {31'h0, zero}, 32'h1);
    chk("rst.done",  {31'h0, done}, 32'h0);
    chk("rst.tick",  {31'h0, tick}, 32'h0);
    chk("rst.blink", {31'h0, blink}, 32'h0);

    // Running at 0000 must never tick.
    step();
    run = 1'b1;
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (tick || done) cnt++;
    end
    chk("zero_run.events", cnt, 0);
    chk("zero_run.bcd", {16'h0, bcd}, 32'h0);
`ifdef BCD_COUNTDOWN_BLINK_EN
    chk("zero_run.blink", {31'h0, blink}, 32'h1);
`else
    chk("zero_run.blink", {31'h0, blink}, 32'h0);
`endif
    run = 1'b0;

    // Load sanitise table, run held low.
    for (int i = 0; i < 8; i++) begin
      do_load(lvec[i].lv, 1'b0);
      push_exp(lvec[i].exp_bcd, lvec[i].exp_zero, 1'b0);
      pop_check("load_tab");
      chk("load_tab.tick", {31'h0, tick}, 32'h0);
      step();
      chk("load_tab.hold", {16'h0, bcd}, {16'h0, lvec[i].exp_bcd});
    end

    // One-tick decrement table.
    for (int i = 0; i < 7; i++) begin
      do_load(dvec[i].lv, 1'b1);
      push_exp(dvec[i].exp_bcd, dvec[i].exp_bcd == 16'h0, dvec[i].exp_done);
      wait_tick(20, cyc, seen);
      chk("dec_tab.seen", {31'h0, seen}, 32'h1);
      chk("dec_tab.cycles", cyc, 10);
      pop_check("dec_tab");
      step();
      chk("dec_tab.tick_1cyc", {31'h0, tick}, 32'h0);
      chk("dec_tab.done_1cyc", {31'h0, done}, 32'h0);
    end
    run = 1'b0;

    // 0105 counts down through 0100 to 0059.
    do_load(16'h0105, 1'b1);
    for (int i = 0; i < 5; i++) wait_tick(20, cyc, seen);
    push_exp(16'h0100, 1'b0, 1'b0);
    pop_check("seq2.0100");
    wait_tick(20, cyc, seen);
    chk("seq2.cycles", cyc, 10);
    push_exp(16'h0059, 1'b0, 1'b0);
    pop_check("seq2.0059");

    // 0001 reaches zero, pulses once, then holds.
    do_load(16'h0001, 1'b1);
    wait_tick(20, cyc, seen);
    chk("seq3.cycles", cyc, 10);
    push_exp(16'h0000, 1'b1, 1'b1);
    pop_check("seq3.hit");
    step();
    chk("seq3.done_low", {31'h0, done}, 32'h0);
    chk("seq3.tick_low", {31'h0, tick}, 32'h0);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (tick || done || bcd != 16'h0) cnt++;
    end
    chk("seq3.hold", cnt, 0);

    // Pause and resume: the prescaler restarts a full period.
    do_load(16'h0200, 1'b1);
    for (int i = 0; i < 6; i++) step();
    run = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (tick) cnt++;
    end
    chk("seq5.pause_ticks", cnt, 0);
    chk("seq5.pause_bcd", {16'h0, bcd}, 32'h0200);
    run = 1'b1;
    wait_tick(20, cyc, seen);
    chk("seq5.resume_cycles", cyc, 10);
    chk("seq5.resume_bcd", {16'h0, bcd}, 32'h0159);
    cnt = 0;
    for (int i = 0; i < 9; i++) begin
      step();
      if (tick) cnt++;
    end
    chk("seq5.pre_tc_ticks", cnt, 0);
    do_load(16'h0333, 1'b1);
    chk("seq5.load_on_tc_bcd", {16'h0, bcd}, 32'h0333);
    chk("seq5.load_on_tc_tick", {31'h0, tick}, 32'h0);
    chk("seq5.load_on_tc_done", {31'h0, done}, 32'h0);
    wait_tick(20, cyc, seen);
    chk("seq5.after_load_cycles", cyc, 10);
    chk("seq5.after_load_bcd", {16'h0, bcd}, 32'h0332);

    // Long divisor gives no tick; a switch to turbo fires at once because of the >= compare.
    turbosim = 1'b0;
    do_load(16'h0010, 1'b1);
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (tick) cnt++;
    end
    chk("slow.ticks", cnt, 0);
    turbosim = 1'b1;
    wait_tick(20, cyc, seen);
    chk("slow.switch_cycles", cyc, 1);
    chk("slow.switch_bcd", {16'h0, bcd}, 32'h0009);

    // Loading 0000 while counting: zero without done.
    do_load(16'h0000, 1'b1);
    chk("load0.zero", {31'h0, zero}, 32'h1);
    chk("load0.done", {31'h0, done}, 32'h0);
    step();
    chk("load0.done_after", {31'h0, done}, 32'h0);

    // Blink shape while counting.
    do_load(16'h0530, 1'b1);
    cnt2 = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (blink) cnt2++;
    end
`ifdef BCD_COUNTDOWN_BLINK_EN
    exp_blink_hi = 5;
`else
    exp_blink_hi = 0;
`endif
    chk("blink.high_cycles", cnt2, exp_blink_hi);
    chk("blink.bcd", {16'h0, bcd}, 32'h0529);

    // Asynchronous reset in mid-count.
    do_load(16'h0530, 1'b1);
    for (int i = 0; i < 4; i++) step();
    #2 reset_n = 1'b0;
    #1;
    chk("arst.bcd",   {16'h0, bcd},  32'h0);
    chk("arst.zero",  {31'h0, zero}, 32'h1);
    chk("arst.tick",  {31'h0, tick}, 32'h0);
    chk("arst.blink", {31'h0, blink}, 32'h0);
    run = 1'b0;
    #10 reset_n = 1'b1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
